demux1_16_deser: RTL and testbench

- Receiving end of the 16:1 mux path: the mux serialises a 16-bit word W by stepping its 4-bit select S16 through 0..15.
- This block accepts that serial bit stream one bit per valid cycle.
- It demultiplexes each bit into position S16 of a 16-bit word and presents the completed word W with a one-cycle done strobe.
- It sits directly after the serialiser/mux stage and feeds downstream parallel logic.

---
 rtl/demux1_16_deser_if.sv | 23 ++
 rtl/demux1_16_deser.sv | 126 ++++++++++++
 tb/tb_demux1_16_deser.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/demux1_16_deser_if.sv
// Bus bundle between the 16:1 serialiser path and the 1:16 deserialiser.
// slave  : seen from the deserialiser (takes serial bits, drives the word).
// master : seen from the stimulus/upstream side.
interface demux1_16_deser_if;
    logic        start;
    logic        din;
    logic        din_valid;
    logic [0:15] W;
    logic [3:0]  S16;
    logic        busy;
    logic        done;
    logic        parity_err;

    modport slave (
        input  start, din, din_valid,
        output W, S16, busy, done, parity_err
    );

    modport master (
        output start, din, din_valid,
        input  W, S16, busy, done, parity_err
    );
endinterface

// File: rtl/demux1_16_deser.sv
// 1:16 serial-to-parallel deserialiser. Bit k of the stream lands in W[k].
// W changes only when a whole word has arrived, together with a one-cycle
// done strobe.
// Optional macro DEMUX1_16_PARITY_EN adds a trailing even-parity bit that is
// checked after bit 15 (extra PAR state); without it parity_err is 0.
module demux1_16_deser (
    input  logic             clk,
    input  logic             rst,
    demux1_16_deser_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
`ifdef DEMUX1_16_PARITY_EN
        PAR  = 2'd2,
`endif
        DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  s16_q, s16_d;
    logic [0:15] word_buf_q, word_buf_d;
    logic [0:15] w_q, w_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        perr_q, perr_d;

    // State and output registers; reset discards any word in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            s16_q      <= 4'd0;
            word_buf_q <= 16'h0000;
            w_q        <= 16'h0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s16_q      <= s16_d;
            word_buf_q <= word_buf_d;
            w_q        <= w_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE and DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: begin
                if (bus.din_valid && s16_q == 4'd15) begin
`ifdef DEMUX1_16_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef DEMUX1_16_PARITY_EN
            PAR:  if (bus.din_valid) state_d = DONE;
`endif
            DONE: state_d = bus.start ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered-output values for the coming cycle.
    always_comb begin
        s16_d      = s16_q;
        word_buf_d = word_buf_q;
        w_d        = w_q;
        perr_d     = perr_q;
        busy_d     = (state_d == LOAD)
`ifdef DEMUX1_16_PARITY_EN
                     || (state_d == PAR)
`endif
                     ;
        done_d     = (state_d == DONE);
        case (state_q)
            IDLE, DONE: begin
                // Fresh word starts from a clean buffer at index 0.
                s16_d = 4'd0;
                if (bus.start) word_buf_d = 16'h0000;
            end
            LOAD: begin
                if (bus.din_valid) begin
                    word_buf_d[s16_q] = bus.din;
                    // 4-bit add wraps 15 -> 0 exactly on the last bit.
                    s16_d = s16_q + 4'd1;
`ifndef DEMUX1_16_PARITY_EN
                    // Last bit is merged on the same edge it is sampled.
                    if (s16_q == 4'd15) w_d = word_buf_d;
`endif
                end
            end
`ifdef DEMUX1_16_PARITY_EN
            PAR: begin
                if (bus.din_valid) begin
                    w_d    = word_buf_q;
                    perr_d = ^{word_buf_q, bus.din};
                end
            end
`endif
            default: s16_d = 4'd0;
        endcase
    end

    assign bus.W    = w_q;
    assign bus.S16  = s16_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef DEMUX1_16_PARITY_EN
    assign bus.parity_err = perr_q;
`else
    // Port kept for interface stability; the flop is unused here.
    assign bus.parity_err = 1'b0;
    logic unused_perr;
    assign unused_perr = perr_q;
`endif

endmodule

// File: tb/tb_demux1_16_deser.sv
// Scoreboard bench for demux1_16_deser: the driver pushes the expected word,
// parity flag and completion cycle; a monitor pops on every done strobe.
module tb_demux1_16_deser;

    logic clk;
    logic rst;
    demux1_16_deser_if bus_if();

    demux1_16_deser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

`ifdef DEMUX1_16_PARITY_EN
    localparam int LAT_EXTRA = 1;
`else
    localparam int LAT_EXTRA = 0;
`endif

    typedef struct {
        logic [0:15] w;
        logic        perr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   done_exp = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done strobe must match the oldest pending word.
    always @(negedge clk) begin
        if (!rst && bus_if.done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("word_W", {16'h0, bus_if.W}, {16'h0, e.w});
                check("parity_err", {31'h0, bus_if.parity_err}, {31'h0, e.perr});
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", {31'h0, bus_if.busy}, 32'd0);
                check("s16_in_done", {28'h0, bus_if.S16}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Assumes we sit just after an edge (IDLE or DONE cycle).
    task automatic begin_word();
        bus_if.start = 1'b1;
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        check("busy_after_start", {31'h0, bus_if.busy}, 32'd1);
        check("s16_after_start", {28'h0, bus_if.S16}, 32'd0);
    endtask

    // Sends one word MSB-of-literal first (= W[0] first), optional gap before
    // bit gap_at, optional start pulse alongside bit mid_start.
    task automatic send_bits(input logic [0:15] w, input logic p, input int gap_at,
                             input int gap_len, input int mid_start);
        exp_t e;
        int   gaps;
        gaps = (gap_at >= 0) ? gap_len : 0;
        e.w    = w;
        e.perr = (LAT_EXTRA == 1) ? ^{w, p} : 1'b0;
        e.cyc  = cyc + 16 + gaps + LAT_EXTRA;
        sb.push_back(e);
        done_exp++;
        for (int i = 0; i < 16; i++) begin
            if (i == gap_at) begin
                bus_if.din_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    check("s16_hold_gap", {28'h0, bus_if.S16}, i);
                end
            end
            bus_if.din       = w[i];
            bus_if.din_valid = 1'b1;
            bus_if.start     = (i == mid_start);
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            if (i == mid_start) begin
                check("s16_mid_start", {28'h0, bus_if.S16}, i + 1);
                check("busy_mid_start", {31'h0, bus_if.busy}, 32'd1);
            end
        end
`ifdef DEMUX1_16_PARITY_EN
        bus_if.din = p;
        @(posedge clk); #1;
`endif
        bus_if.din_valid = 1'b0;
        bus_if.din       = 1'b0;
    endtask

    initial begin
        logic [0:15] part;
        rst = 1'b1;
        bus_if.start = 1'b0;
        bus_if.din = 1'b0;
        bus_if.din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_W", {16'h0, bus_if.W}, 32'h0);
        check("rst_S16", {28'h0, bus_if.S16}, 32'd0);
        check("rst_busy", {31'h0, bus_if.busy}, 32'd0);
        check("rst_done", {31'h0, bus_if.done}, 32'd0);
        check("rst_perr", {31'h0, bus_if.parity_err}, 32'd0);
        rst = 1'b0;
        idle(1);

        // Bits in IDLE are ignored.
        bus_if.din = 1'b1; bus_if.din_valid = 1'b1;
        idle(2);
        bus_if.din = 1'b0; bus_if.din_valid = 1'b0;
        check("idle_S16", {28'h0, bus_if.S16}, 32'd0);
        check("idle_busy", {31'h0, bus_if.busy}, 32'd0);

        // Gapless A5C3.
        begin_word();
        send_bits(16'hA5C3, 1'b0, -1, 0, -1);
        idle(2);
        check("idle_after_done", {31'h0, bus_if.done}, 32'd0);

        // A5C3 with 3-cycle gap after bit 7.
        begin_word();
        send_bits(16'hA5C3, 1'b0, 8, 3, -1);
        idle(2);

        // FFFF, then abort 0001 after 9 bits with a mid-cycle reset.
        begin_word();
        send_bits(16'hFFFF, 1'b1, -1, 0, -1);
        idle(2);
        begin_word();
        part = 16'h0001;
        for (int i = 0; i < 9; i++) begin
            bus_if.din = part[i]; bus_if.din_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus_if.din_valid = 1'b0;
        check("s16_before_abort", {28'h0, bus_if.S16}, 32'd9);
        #2 rst = 1'b1;
        #1;
        check("abort_W", {16'h0, bus_if.W}, 32'h0);
        check("abort_S16", {28'h0, bus_if.S16}, 32'd0);
        check("abort_busy", {31'h0, bus_if.busy}, 32'd0);
        @(posedge clk); #3 rst = 1'b0;
        idle(2);
        begin_word();
        send_bits(16'h1234, 1'b0, -1, 0, -1);
        idle(1);
        check("W_holds_1234", {16'h0, bus_if.W}, 32'h1234);

        // Back-to-back: start asserted during DONE.
        begin_word();
        send_bits(16'h00FF, 1'b0, -1, 0, -1);
        begin_word();
        send_bits(16'hFF00, 1'b0, -1, 0, -1);
        idle(2);

        // start pulsed during LOAD after 5 bits is ignored.
        begin_word();
        send_bits(16'h5A3C, 1'b0, -1, 0, 5);
        idle(2);

`ifdef DEMUX1_16_PARITY_EN
        begin_word();
        send_bits(16'h0007, 1'b1, -1, 0, -1);
        idle(2);
        begin_word();
        send_bits(16'h0007, 1'b0, -1, 0, -1);
        idle(2);
`endif

        idle(3);
        check("pending_words", sb.size(), 32'd0);
        check("done_count", done_seen, done_exp);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
